// File: rtl/debounce_pkg.sv
// Shared defaults and width helper for the button debouncer slice.
package debounce_pkg;

  localparam int DEF_CHANNELS     = 5;
  localparam int DEF_TICK_DIV     = 524288;
  localparam int DEF_STABLE_TICKS = 4;
  localparam bit DEF_ACTIVE_LOW   = 1'b0;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w = w + 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// Free-running prescaler producing a one-cycle sample enable every TICK_DIV cycles.
module debounce_tick_gen
  import debounce_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk_100MHz,
  input  logic clr_n,
  output logic tick
);

  localparam int            CW   = clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: registers use non-blocking (<=) so every flop sees pre-edge values regardless of statement order.
  always_ff @(posedge clk_100MHz or negedge clr_n) begin
    if (!clr_n)             count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CW'(1);
  end

  // A clock enable for the sampling logic, not a clock.
  assign tick = (count == LAST);

endmodule

// File: rtl/multi_btn_debouncer.sv
// Multi-channel button debouncer: synchronize, sample on tick, accept a level after STABLE_TICKS differing samples.
module multi_btn_debouncer
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter bit ACTIVE_LOW   = DEF_ACTIVE_LOW
) (
  input  logic                clk_100MHz,
  input  logic                clr_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_rise,
  output logic [CHANNELS-1:0] btn_fall,
  output logic                tick
);

  localparam int            SW       = clog2(STABLE_TICKS + 1);
  localparam logic [SW-1:0] LAST_CNT = SW'(STABLE_TICKS - 1);
  localparam logic [CHANNELS-1:0] IDLE_RAW = {CHANNELS{ACTIVE_LOW}};

  logic [CHANNELS-1:0] sync_meta;
  logic [CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0] sample;

  debounce_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_100MHz (clk_100MHz),
    .clr_n      (clr_n),
    .tick       (tick)
  );

  // Reset to the idle raw level so a released button looks unchanged after reset.
  always_ff @(posedge clk_100MHz or negedge clr_n) begin
    if (!clr_n) begin
      sync_meta <= IDLE_RAW;
      sync_q    <= IDLE_RAW;
    end else begin
      sync_meta <= btn_in;
      sync_q    <= sync_meta;
    end
  end

  assign sample = sync_q ^ IDLE_RAW;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SW-1:0] stable_cnt;
    logic [SW-1:0] cnt_next;
    logic          level_q;
    logic          level_next;
    logic          rise_q;
    logic          fall_q;

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
      cnt_next   = stable_cnt;
      level_next = level_q;
      if (tick) begin
        if (sample[i] == level_q) begin
          cnt_next = '0;
        end else if (stable_cnt == LAST_CNT) begin
          level_next = ~level_q;
          cnt_next   = '0;
        end else begin
          cnt_next = stable_cnt + SW'(1);
        end
      end
    end

    // Edge pulses are registered alongside the level so they line up with its first new cycle.
    always_ff @(posedge clk_100MHz or negedge clr_n) begin
      if (!clr_n) begin
        stable_cnt <= '0;
        level_q    <= 1'b0;
        rise_q     <= 1'b0;
        fall_q     <= 1'b0;
      end else begin
        stable_cnt <= cnt_next;
        level_q    <= level_next;
        rise_q     <= level_next & ~level_q;
        fall_q     <= ~level_next & level_q;
      end
    end

    assign btn_level[i] = level_q;
    assign btn_rise[i]  = rise_q;
    assign btn_fall[i]  = fall_q;
  end

endmodule

// File: tb/tb_multi_btn_debouncer.sv
// Bench for multi_btn_debouncer: an active-high and an active-low instance, each checked every cycle against a sample-history model.
module tb_multi_btn_debouncer;

  localparam int CH = 2;
  localparam int TD = 4;
  localparam int ST = 3;

  logic          clk_100MHz = 1'b0;
  logic          clr_n;
  logic [CH-1:0] btn  [2];
  logic [CH-1:0] lvl  [2];
  logic [CH-1:0] rise [2];
  logic [CH-1:0] fall [2];
  logic          tk   [2];

  int   n_tests = 0;
  int   n_fail  = 0;
  logic cmp_en  = 1'b0;
  int   cyc     = 0;
  int   pulses0 = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Streak of consecutive tick samples disagreeing with the accepted level; the level flips on the ST-th one.
  function automatic int f_streak(input int s, input bit smp, input bit lv, input bit tick_now);
    if (!tick_now)     return s;
    if (smp == lv)     return 0;
    if (s + 1 >= ST)   return 0;
    return s + 1;
  endfunction

  function automatic bit f_level(input int s, input bit smp, input bit lv, input bit tick_now);
    return (tick_now && smp != lv && s + 1 >= ST) ? ~lv : lv;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam bit AL = (g == 1);

    int            m_n;
    logic [CH-1:0] m_h0, m_h1, m_lvl, m_rise, m_fall;
    int            m_streak [CH];

    multi_btn_debouncer #(
      .CHANNELS     (CH),
      .TICK_DIV     (TD),
      .STABLE_TICKS (ST),
      .ACTIVE_LOW   (AL)
    ) dut (
      .clk_100MHz (clk_100MHz),
      .clr_n      (clr_n),
      .btn_in     (btn[g]),
      .btn_level  (lvl[g]),
      .btn_rise   (rise[g]),
      .btn_fall   (fall[g]),
      .tick       (tk[g])
    );

    // Model: raw input seen two edges late, sampled when the cycle count since reset hits TD-1 mod TD.
    always @(posedge clk_100MHz or negedge clr_n) begin
      if (!clr_n) begin
        m_n    <= 0;
        m_h0   <= {CH{AL}};
        m_h1   <= {CH{AL}};
        m_lvl  <= '0;
        m_rise <= '0;
        m_fall <= '0;
        for (int c = 0; c < CH; c++) m_streak[c] <= 0;
      end else begin
        for (int c = 0; c < CH; c++) begin
          m_streak[c] <= f_streak(m_streak[c], m_h1[c] ^ AL, m_lvl[c], (m_n % TD) == TD - 1);
          m_lvl[c]    <= f_level(m_streak[c], m_h1[c] ^ AL, m_lvl[c], (m_n % TD) == TD - 1);
          m_rise[c]   <= f_level(m_streak[c], m_h1[c] ^ AL, m_lvl[c], (m_n % TD) == TD - 1) & ~m_lvl[c];
          m_fall[c]   <= ~f_level(m_streak[c], m_h1[c] ^ AL, m_lvl[c], (m_n % TD) == TD - 1) & m_lvl[c];
        end
        m_h1 <= m_h0;
        m_h0 <= btn[g];
        m_n  <= m_n + 1;
      end
    end

    always @(negedge clk_100MHz) begin
      if (cmp_en) begin
        check($sformatf("inst%0d_tick", g), tk[g], ((m_n % TD) == TD - 1));
        check($sformatf("inst%0d_level", g), lvl[g], m_lvl);
        check($sformatf("inst%0d_rise", g), rise[g], m_rise);
        check($sformatf("inst%0d_fall", g), fall[g], m_fall);
        check($sformatf("inst%0d_rise_fall_excl", g), rise[g] & fall[g], 0);
      end
    end
  end

  always @(posedge clk_100MHz or negedge clr_n) begin
    if (!clr_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk_100MHz) begin
    if (cmp_en) pulses0 <= pulses0 + int'(rise[0][0]) + int'(fall[0][0]);
  end

  // Leaves the bench 2 ns after an edge on which a tick was sampled.
  task automatic align();
    do begin
      @(posedge clk_100MHz);
      #1;
    end while (cyc % TD != 0);
    #1;
  endtask

  task automatic hold_cycles(input int n);
    repeat (n) @(posedge clk_100MHz);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic bseq [7];
    int   p0;
    bseq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    clr_n  = 1'b0;
    btn[0] = 2'b00;
    btn[1] = 2'b11;
    repeat (2) @(posedge clk_100MHz);
    cmp_en = 1'b1;
    hold_cycles(8);
    clr_n = 1'b1;

    // Reset release: outputs idle, tick in cycles 4 and 8 after release.
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_100MHz);
      check("tick_after_release", tk[0], (k == 4 || k == 8));
      if (k == 1) begin
        check("rst_level0", lvl[0], 2'b00);
        check("rst_pulses0", {rise[0], fall[0]}, 4'b0000);
        check("rst_level1_active_low_idle", lvl[1], 2'b00);
        check("rst_pulses1", {rise[1], fall[1]}, 4'b0000);
      end
    end

    // Active-low instance: ch1 driven low, accepted on the 3rd tick.
    align();
    btn[1][1] = 1'b0;
    repeat (11) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    check("al_before_accept", {lvl[1], rise[1]}, 4'b0000);
    @(negedge clk_100MHz);
    check("al_accept_level", lvl[1], 2'b10);
    check("al_accept_rise", rise[1], 2'b10);
    @(negedge clk_100MHz);
    check("al_rise_one_cycle", rise[1], 2'b00);
    btn[1][1] = 1'b1;

    // Bounce on ch0 of the active-high instance: never three agreeing samples.
    align();
    p0 = pulses0;
    for (int i = 0; i < 7; i++) begin
      btn[0][0] = bseq[i];
      hold_cycles(4);
    end
    hold_cycles(16);
    check("bounce_level", lvl[0][0], 1'b0);
    check("bounce_no_pulses", pulses0 - p0, 0);

    // Clean press on ch0; ch1 stays released.
    align();
    btn[0][0] = 1'b1;
    repeat (11) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    check("press_before_accept", {lvl[0], rise[0]}, 4'b0000);
    @(negedge clk_100MHz);
    check("press_level", lvl[0], 2'b01);
    check("press_rise", rise[0], 2'b01);
    check("press_no_fall", fall[0], 2'b00);
    @(negedge clk_100MHz);
    check("press_rise_one_cycle", {lvl[0], rise[0]}, 4'b0100);

    // Press ch1, then release both channels together.
    align();
    btn[0][1] = 1'b1;
    hold_cycles(16);
    check("both_pressed", lvl[0], 2'b11);
    align();
    btn[0] = 2'b00;
    repeat (11) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    check("release_before_accept", {lvl[0], fall[0]}, 4'b1100);
    @(negedge clk_100MHz);
    check("release_level", lvl[0], 2'b00);
    check("release_fall_both", fall[0], 2'b11);
    check("release_no_rise", rise[0], 2'b00);
    @(negedge clk_100MHz);
    check("release_fall_one_cycle", fall[0], 2'b00);

    // Reset mid-count: ch1 held pressed, ch0 two ticks into a press.
    align();
    btn[0][1] = 1'b1;
    hold_cycles(16);
    check("pre_reset_ch1_level", lvl[0], 2'b10);
    align();
    btn[0][0] = 1'b1;
    hold_cycles(8);
    clr_n = 1'b0;
    @(negedge clk_100MHz);
    check("midrst_level", lvl[0], 2'b00);
    check("midrst_no_pulses", {rise[0], fall[0]}, 4'b0000);
    check("midrst_tick", tk[0], 1'b0);
    @(posedge clk_100MHz);
    #2;
    clr_n = 1'b1;
    repeat (11) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    check("postrst_before_accept", {lvl[0], rise[0], fall[0]}, 6'b000000);
    @(negedge clk_100MHz);
    check("postrst_level", lvl[0], 2'b11);
    check("postrst_rise", rise[0], 2'b11);

    hold_cycles(8);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_btn_debouncer.md
MULTI_BTN_DEBOUNCER -- requirements
Module: multi_btn_debouncer

Interface
REQ-001 Parameter CHANNELS, default 5: number of independent button channels, legal range 1..32.
REQ-002 Parameter TICK_DIV, default 524288: clock cycles per sample tick (about 190.7 Hz at 100 MHz), legal minimum 2.
REQ-003 Parameter STABLE_TICKS, default 4: consecutive differing samples required to accept a new level, legal range 1..255.
REQ-004 Parameter ACTIVE_LOW, default 0: 1 means a raw input reads 0 when pressed.
REQ-005 Port clk_100MHz, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-006 Port clr_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port btn_in, input, CHANNELS bits: raw, asynchronous, bouncing button inputs.
REQ-008 Port btn_level, output, CHANNELS bits: debounced level per channel, 1 = pressed.
REQ-009 Port btn_rise, output, CHANNELS bits: one-cycle pulse per channel on each accepted press.
REQ-010 Port btn_fall, output, CHANNELS bits: one-cycle pulse per channel on each accepted release.
REQ-011 Port tick, output, 1 bit: sample strobe, high for exactly one cycle every TICK_DIV cycles.

Function
REQ-012 The prescaler counter SHALL count 0..TICK_DIV-1 and wrap to 0, with width clog2(TICK_DIV).
REQ-013 tick SHALL be high in the cycle where the prescaler equals TICK_DIV-1; it is a clock enable, never a derived clock.
REQ-014 Each channel SHALL pass through a 2-flop synchronizer, and the synchronized value SHALL then be XORed with ACTIVE_LOW to form the normalized sample.
REQ-015 Each channel SHALL hold a stability counter of width clog2(STABLE_TICKS+1).
REQ-016 On tick, when sample == btn_level, the channel's stability counter SHALL clear to 0.
REQ-017 On tick, when sample != btn_level and the counter is below STABLE_TICKS-1, the counter SHALL increment.
REQ-018 On tick, when sample != btn_level and the counter equals STABLE_TICKS-1, btn_level SHALL toggle and the counter SHALL clear.
REQ-019 Between ticks, all counters and btn_level SHALL hold their values.
REQ-020 btn_rise[i] SHALL be high for exactly the one cycle in which btn_level[i] first reads 1 after reading 0.
REQ-021 btn_fall[i] SHALL be high for exactly the one cycle in which btn_level[i] first reads 0 after reading 1.
REQ-022 btn_rise and btn_fall SHALL never be high together on the same channel.
REQ-023 Latency from a clean raw transition to btn_level change SHALL be 2 cycles of synchronization plus between STABLE_TICKS-1 and STABLE_TICKS tick periods.
REQ-024 Any matching sample before STABLE_TICKS is reached SHALL discard the partial count, which is how glitches are rejected.
REQ-025 Channels SHALL be fully independent, and simultaneous transitions on several channels SHALL be accepted on the same tick.

Reset
REQ-026 While clr_n = 0: prescaler = 0, all stability counters = 0, btn_level = 0, btn_rise = 0, btn_fall = 0, tick = 0.
REQ-027 Synchronizer flops SHALL reset to ACTIVE_LOW so that an idle button produces no spurious change.
REQ-028 The first tick after clr_n rises SHALL occur TICK_DIV cycles later.
REQ-029 Reset asserted mid-count SHALL discard all partial counts, and no edge pulse SHALL be emitted because of the reset.

Structure
REQ-030 The default parameter values and a clog2 helper SHALL live in the shared package debounce_pkg.
REQ-031 The prescaler SHALL be a sub-module debounce_tick_gen (parameter TICK_DIV; ports clk_100MHz, clr_n, tick), instantiated once.
REQ-032 The per-channel logic SHALL be a generate loop over CHANNELS inside multi_btn_debouncer.

Verification (bench settings: CHANNELS = 2, TICK_DIV = 4, STABLE_TICKS = 3)
REQ-033 Reset: hold clr_n = 0 for 10 cycles, then release -> all outputs 0, and tick first high in cycle 4 after release, then every 4 cycles.
REQ-034 Clean press: btn_in[0] goes 0->1 and is held -> btn_level[0] = 1 on the 3rd tick that samples 1; btn_rise[0] is one-cycle high; channel 1 does not change.
REQ-035 Bounce: ch0 samples 1,0,1,1,0,1,0 on successive ticks -> btn_level[0] stays 0 and no pulses occur.
REQ-036 Release, with both channels at the same time: both pressed, then both raw inputs go to 0 together -> both btn_fall bits pulse in the same cycle, 3 ticks later.
REQ-037 ACTIVE_LOW = 1: btn_in = 2'b11 through reset -> btn_level = 0 with no pulses; btn_in[1] driven to 0 for 3 ticks -> btn_level[1] = 1 and btn_rise[1] pulses.
REQ-038 Reset mid-operation: ch0 stability counter = 2, then clr_n pulsed low for 1 cycle -> counter 0 and btn_level 0; with the input still 1, a press is accepted only after 3 new ticks.
